// File: rtl/usb_rx.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rx (with package usb_rx_pkg)
//  Purpose  : USB Low Speed (1.5 Mbit/s) receiver, receive half of the SIE
//             line interface. Recovers bit timing at 16x oversampling,
//             detects SYNC, NRZI-decodes, removes stuffed bits, assembles
//             bytes LSB-first, and reports EOP and stuff/framing errors.
//  Ports    : clk     - 24 MHz system clock
//             reset   - asynchronous active-low reset (0 = reset)
//             d_i     - D+/D- line pair, asynchronous to clk
//             rx_en   - receiver enable (tie to ~d_en of the transmitter)
//             data    - last received byte, held until the next valid
//             valid   - one-cycle strobe, new byte on data
//             active  - high from SYNC accepted until EOP or abort
//             eop     - one-cycle strobe, packet ended cleanly
//             error   - one-cycle strobe, stuff error / SE1 / EOP mid-byte
//  Revision : 1.0 - initial release
// ============================================================================

package usb_rx_pkg;
  // Low speed line states: J = D+ low / D- high, K = D+ high / D- low.
  typedef struct packed {
    logic dp;
    logic dm;
  } d_port_t;

  localparam d_port_t LINE_J   = 2'b01;
  localparam d_port_t LINE_K   = 2'b10;
  localparam d_port_t LINE_SE0 = 2'b00;
  localparam d_port_t LINE_SE1 = 2'b11;
endpackage

module usb_rx
  import usb_rx_pkg::*;
#(
  parameter int CLK_PER_BIT  = 16,
  parameter int SAMPLE_PHASE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d_i,
  input  logic       rx_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       active,
  output logic       eop,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_DATA  = 3'd2,
    S_EOP   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [3:0] PH_LAST  = 4'(CLK_PER_BIT - 1);
  localparam logic [3:0] PH_STRB  = 4'(SAMPLE_PHASE - 1);
  localparam logic [7:0] SYNC_PAT = 8'h80;

  state_t     state, state_nx;
  d_port_t    sync_q1, line, line_q;
  logic [3:0] phase;
  logic       prev_lvl;     // previous sampled level as D+ (J = 0, K = 1)
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [2:0] ones_cnt;
  logic [3:0] sync_cnt;
  logic       j_seen;       // last ABORT strobe saw J

  logic       line_j, line_k, line_se0, line_se1, jk_edge, strobe, dbit;
  logic [7:0] shifted;
  logic       valid_nx, eop_nx, err_nx;
  logic       enter_sync, sync_shift, take_bit, drop_stuff;

  assign line_j   = (line == LINE_J);
  assign line_k   = (line == LINE_K);
  assign line_se0 = (line == LINE_SE0);
  assign line_se1 = (line == LINE_SE1);
  // Only J<->K transitions carry timing; SE0/SE1 edges are not used to resync.
  assign jk_edge  = (line_j && (line_q == LINE_K)) || (line_k && (line_q == LINE_J));
  assign strobe   = (phase == PH_STRB);
  assign dbit     = (line.dp == prev_lvl);
  assign shifted  = {dbit, shreg[7:1]};

  // --------------------------------------------------------------------------
  // Next-state and pulse decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    valid_nx   = 1'b0;
    eop_nx     = 1'b0;
    err_nx     = 1'b0;
    enter_sync = 1'b0;
    sync_shift = 1'b0;
    take_bit   = 1'b0;
    drop_stuff = 1'b0;
    if (!rx_en) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (line_k) begin
            state_nx   = S_SYNC;
            enter_sync = 1'b1;
          end
        end
        S_SYNC: begin
          if (strobe) begin
            if (line_se0) begin
              state_nx = S_IDLE;
            end else if (shifted == SYNC_PAT) begin
              state_nx = S_DATA;
            end else if (sync_cnt == 4'd15) begin
              state_nx = S_IDLE;
            end else begin
              sync_shift = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (strobe) begin
            if (line_se1) begin
              err_nx   = 1'b1;
              state_nx = S_ABORT;
            end else if (line_se0) begin
              if (bit_cnt == 3'd0) begin
                state_nx = S_EOP;
              end else begin
                err_nx   = 1'b1;
                state_nx = S_ABORT;
              end
            end else if (ones_cnt == 3'd6) begin
              if (dbit) begin
                err_nx   = 1'b1;
                state_nx = S_ABORT;
              end else begin
                drop_stuff = 1'b1;
              end
            end else begin
              take_bit = 1'b1;
              valid_nx = (bit_cnt == 3'd7);
            end
          end
        end
        S_EOP: begin
          if (strobe) begin
            if (line_j) begin
              eop_nx   = 1'b1;
              state_nx = S_IDLE;
            end else if (line_k || line_se1) begin
              err_nx   = 1'b1;
              state_nx = S_ABORT;
            end
          end
        end
        S_ABORT: begin
          if (strobe && line_j && j_seen) begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Input synchronizer, bit timing and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1  <= LINE_J;
      line     <= LINE_J;
      line_q   <= LINE_J;
      phase    <= 4'd0;
      prev_lvl <= 1'b0;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      ones_cnt <= 3'd0;
      sync_cnt <= 4'd0;
      j_seen   <= 1'b0;
      data     <= 8'h00;
      valid    <= 1'b0;
      eop      <= 1'b0;
      error    <= 1'b0;
      active   <= 1'b0;
    end else begin
      sync_q1 <= d_i;
      line    <= sync_q1;
      line_q  <= line;

      if (((state == S_IDLE) && line_j) || jk_edge || (phase == PH_LAST)) begin
        phase <= 4'd0;
      end else begin
        phase <= phase + 4'd1;
      end

      if (strobe) begin
        prev_lvl <= line.dp;
      end

      // Seeding with all ones keeps the SYNC compare from matching before a
      // full eight decoded bits have been shifted in.
      if (enter_sync) begin
        prev_lvl <= 1'b0;
        shreg    <= 8'hFF;
        sync_cnt <= 4'd0;
      end

      if (sync_shift) begin
        shreg    <= shifted;
        sync_cnt <= sync_cnt + 4'd1;
      end

      if ((state == S_SYNC) && (state_nx == S_DATA)) begin
        bit_cnt  <= 3'd0;
        ones_cnt <= 3'd0;
      end

      if (take_bit) begin
        shreg    <= shifted;
        bit_cnt  <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
        ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
        if (bit_cnt == 3'd7) begin
          data <= shifted;
        end
      end

      if (drop_stuff) begin
        ones_cnt <= 3'd0;
      end

      if (state != S_ABORT) begin
        j_seen <= 1'b0;
      end else if (strobe) begin
        j_seen <= line_j;
      end

      valid  <= valid_nx;
      eop    <= eop_nx;
      error  <= err_nx;
      active <= (state_nx == S_DATA) || (state_nx == S_EOP);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_rx
//  Purpose  : Self-checking bench for usb_rx. Stimulus tasks NRZI-encode and
//             bit-stuff bytes onto D+/D- and push the expected byte/eop/error
//             events into a queue; a monitor pops and compares on each pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx;
  import usb_rx_pkg::*;

  localparam d_port_t J   = 2'b01;
  localparam d_port_t K   = 2'b10;
  localparam d_port_t SE0 = 2'b00;

  localparam int EV_VALID = 0;
  localparam int EV_EOP   = 1;
  localparam int EV_ERR   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_en = 1'b1;
  d_port_t    d_i = J;
  logic [7:0] data;
  logic       valid, active, eop, error;

  usb_rx #(.CLK_PER_BIT(16), .SAMPLE_PHASE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .d_i   (d_i),
    .rx_en (rx_en),
    .data  (data),
    .valid (valid),
    .active(active),
    .eop   (eop),
    .error (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] dat;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // encoder state
  logic lvl_k    = 1'b0;
  int   ones     = 0;
  bit   alt_mode = 1'b0;
  bit   alt_long = 1'b0;

  function automatic string ev_name(int k);
    case (k)
      EV_VALID: return "valid";
      EV_EOP:   return "eop";
      default:  return "error";
    endcase
  endfunction

  task automatic push(int k, logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.dat  = d;
    expq.push_back(e);
  endtask

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One line symbol lasting one bit time (16 clk, or alternately 15/17).
  task automatic sym(d_port_t v);
    int n;
    n = alt_mode ? (alt_long ? 17 : 15) : 16;
    alt_long = ~alt_long;
    d_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nrzi(bit b);
    if (!b) lvl_k = ~lvl_k;
    sym(lvl_k ? K : J);
  endtask

  task automatic send_bit(bit b);
    nrzi(b);
    if (b) begin
      ones++;
      if (ones == 6) begin
        nrzi(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic send_sync();
    lvl_k = 1'b0;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
    ones = 0;
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    sym(SE0);
    sym(SE0);
    sym(J);
    lvl_k = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) sym(J);
    lvl_k = 1'b0;
  endtask

  // Scoreboard monitor
  exp_t mon_e;
  int   mon_kind;
  always @(negedge clk) begin
    if (valid || eop || error) begin
      checks++;
      mon_kind = valid ? EV_VALID : (eop ? EV_EOP : EV_ERR);
      if ((int'(valid) + int'(eop) + int'(error)) > 1) begin
        failures++;
        $display("FAIL pulse_exclusive: got valid=%b eop=%b error=%b expected one", valid, eop, error);
      end else if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got %s data=%h expected none", ev_name(mon_kind), data);
      end else begin
        mon_e = expq.pop_front();
        if ((mon_e.kind != mon_kind) || ((mon_kind == EV_VALID) && (mon_e.dat !== data))) begin
          failures++;
          $display("FAIL event: got %s data=%h expected %s data=%h",
                   ev_name(mon_kind), data, ev_name(mon_e.kind), mon_e.dat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;

    // ---------------- reset with line toggling, then idle ----------------
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      d_i = (i % 2 == 0) ? K : J;
      @(posedge clk);
      #1;
      check("reset_outputs", {data, valid, active, eop, error}, 12'h000);
    end
    d_i   = J;
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("idle_outputs", {data, valid, active, eop, error}, 12'h000);

    // ---------------- single byte A5 ----------------
    push(EV_VALID, 8'hA5);
    push(EV_EOP, 8'h00);
    send_sync();
    check("active_after_sync", {11'h0, active}, 12'h001);
    send_byte(8'hA5);
    check("active_in_packet", {11'h0, active}, 12'h001);
    send_eop();
    idle(2);
    check("active_after_eop", {11'h0, active}, 12'h000);
    check("data_hold_a5", {4'h0, data}, 12'h0A5);

    // ---------------- bit stuffing FF, 7E ----------------
    push(EV_VALID, 8'hFF);
    push(EV_VALID, 8'h7E);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h7E);
    send_eop();
    idle(4);
    check("data_hold_7e", {4'h0, data}, 12'h07E);

    // ---------------- stuff error: seven 1s ----------------
    push(EV_ERR, 8'h00);
    send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b1);
    check("active_after_stuff_err", {11'h0, active}, 12'h000);
    idle(4);
    check("data_after_stuff_err", {4'h0, data}, 12'h07E);

    // ---------------- clock tolerance 15/17 ----------------
    alt_mode = 1'b1;
    push(EV_VALID, 8'h3C);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'h3C);
    send_eop();
    idle(4);
    check("data_3c", {4'h0, data}, 12'h03C);
    push(EV_ERR, 8'h00);
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i));
    sym(SE0);
    sym(SE0);
    idle(4);
    check("active_after_se0_err", {11'h0, active}, 12'h000);
    alt_mode = 1'b0;

    // ---------------- reset during 5th data bit ----------------
    b = 8'hC3;
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    if (!b[4]) lvl_k = ~lvl_k;
    d_i = lvl_k ? K : J;
    repeat (8) @(posedge clk);
    #1;
    check("active_before_reset", {11'h0, active}, 12'h001);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {data, valid, active, eop, error}, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    d_i   = J;
    lvl_k = 1'b0;
    reset = 1'b1;
    idle(4);

    // ---------------- rx_en gating mid-byte ----------------
    b = 8'h96;
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    check("active_before_gate", {11'h0, active}, 12'h001);
    rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("active_gated", {11'h0, active}, 12'h000);
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    send_eop();
    idle(2);
    rx_en = 1'b1;
    idle(2);
    push(EV_VALID, 8'h5A);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'h5A);
    send_eop();
    idle(4);
    check("data_5a", {4'h0, data}, 12'h05A);
    check("queue_drained", 12'(expq.size()), 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rx.md
Name: usb_rx

Overview:
USB Low Speed (1.5 Mbit/s) receiver, the receive half of the SIE line interface.
- Recovers bit timing from D+/D- at 16x oversampling (24 MHz clk).
- Detects SYNC, NRZI-decodes, removes stuffed bits, assembles bytes LSB-first and hands them to the SIE one byte at a time.
- Detects EOP and reports stuffing/framing errors.
- Shares the D+/D- pins with usb_tx; it is gated off while the transmitter drives the bus.

Parameters:
- CLK_PER_BIT, 16, clk cycles per bit (24 MHz / 1.5 MHz).
- SAMPLE_PHASE, 8, phase-counter value at which a bit is sampled (mid-bit).

Ports:
- clk  input  1  system clock, 24 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- d_i  input  d_port_t  USB port D+,D- (input), asynchronous to clk.
- rx_en  input  1  receiver enable; tie to ~d_en of the transmitter.
- data  output  8  received byte; stable from the valid pulse until the next valid.
- valid  output  1  one-cycle strobe: new byte on data.
- active  output  1  high from SYNC accepted until EOP or abort.
- eop  output  1  one-cycle strobe: packet ended cleanly.
- error  output  1  one-cycle strobe: stuff error, SE1, or EOP inside a byte.

Behaviour:
- Reset (reset=0, async): state IDLE; data=8'h00; valid, active, eop and error = 0; all counters 0; NRZI reference level = J.
- Input path: d_i passes through a 2-flop synchronizer (2 clk latency) before any use.
- Phase counter (4 bit):
  - Increments each clk and wraps from CLK_PER_BIT-1 to 0.
  - Reset to 0 on every J<->K change of the synchronized line.
  - Sample strobe fires when the counter equals SAMPLE_PHASE-1.
  - Held at 0 in IDLE while the line is J.
- NRZI decode at each strobe: bit = 1 if the sampled level equals the previous sampled level, else 0. The previous level updates each strobe and is seeded with J on entry to SYNC.
- State machine (IDLE, SYNC, DATA, EOP, ABORT):
  - IDLE -> SYNC: rx_en=1 and the synchronized line is K.
  - SYNC: shifts decoded bits into an 8-bit register at the MSB.
    - Register equals 8'h80 (KJKJKJKK) -> DATA; set active=1; clear bit and ones counters.
    - 16 bit-times without a match, or SE0 -> IDLE, with no error.
  - DATA, at each strobe:
    - Line SE1 -> error, then ABORT.
    - Line SE0 with bit counter == 0 -> EOP.
    - Line SE0 with bit counter != 0 -> error, then ABORT.
    - Ones counter == 6: this bit is a stuff bit. If decoded 0, discard it and clear the counter. If decoded 1, error, then ABORT.
    - Otherwise shift the bit in at the MSB, bump the bit counter, and update the ones counter (+1 on 1, clear on 0).
    - On the 8th bit: data <= assembled byte, and valid=1 the next clk.
  - EOP:
    - Line J at a strobe -> eop=1 for one clk, active=0, then IDLE.
    - Line K or SE1 -> error, then ABORT.
    - SE0 lasting more than 3 bit-times is still accepted and waits for J.
  - ABORT: active=0. Return to IDLE after 2 consecutive J strobes. No further valid, eop or error pulses until then.
- rx_en=0 in any state: go to IDLE synchronously, drop active, and emit no pulses.
- valid, eop and error are mutually exclusive within a cycle and never stretch beyond 1 clk.
- Every counter wraps only by explicit rule; no implicit overflow is relied upon.

Test Plan:
- Reset and idle: hold reset=0 for 5 clk with d_i toggling; then reset=1 with d_i=J for 200 clk -> all outputs stay 0 and active stays 0.
- Single byte: drive SYNC, byte 8'hA5 NRZI-encoded LSB-first, SE0 SE0 J, 16 clk per bit -> active rises after SYNC; one valid pulse with data=8'hA5; one eop pulse in the J bit; active falls with eop.
- Bit stuffing: drive SYNC, 8'hFF, 8'h7E with correct stuff bits inserted, then EOP -> valid pulses with 8'hFF then 8'h7E; no error.
- Stuff error: drive SYNC then seven decoded 1s -> error pulse exactly once at the 7th-bit strobe; active=0; no valid; return to IDLE after 2 J bits.
- Clock tolerance: single-byte packet 8'h3C with bit period alternating 15 and 17 clk -> data=8'h3C and eop with no error. Also send SE0 after 4 data bits -> error, with no valid or eop.
- Mid-packet reset and gating: pull reset low during the 5th data bit -> outputs 0 immediately. Repeat with rx_en=0 mid-byte -> no pulses; next full packet 8'h5A received correctly.
